// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-access stage after the ALU. Accepts one request at a time,
//             runs a handshaked RAM access (wait states allowed) and returns
//             sign/zero-extended load data with a one-cycle response pulse.
//  Options  : MISALIGN_TRAP_EN - when defined, misaligned H/HU/W requests are
//             rejected without a RAM cycle and flagged on RespErr.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 12           // word-address width, must be <= 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [31:0]       AluRes,
    input  logic [31:0]       StoreData,
    input  logic [2:0]        MemOp,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [3:0]        MemBe,
    output logic [31:0]       MemWData,
    input  logic [31:0]       MemRData,
    input  logic              MemAck,
    output logic              RespValid,
    output logic [31:0]       LoadData,
    output logic              RespErr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // funct3[1:0] size field; funct3[2] selects zero extension
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;

    state_t              r_state_q, w_state_d;
    logic [ADDR_W-1:0]   r_addr_q,  w_addr_d;
    logic [3:0]          r_be_q,    w_be_d;
    logic [31:0]         r_wdata_q, w_wdata_d;
    logic                r_we_q,    w_we_d;
    logic [1:0]          r_off_q,   w_off_d;
    logic [2:0]          r_op_q,    w_op_d;
    logic [31:0]         r_load_q,  w_load_d;
`ifdef MISALIGN_TRAP_EN
    logic                r_err_q,   w_err_d;
    logic                w_misalign;
`endif

    logic                w_accept;
    logic [3:0]          w_req_be;
    logic [31:0]         w_req_wdata;
    logic [31:0]         w_fmt;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;

    // Address bits above the RAM window are don't-care
    if (ADDR_W < 30) begin : g_addr_unused
        logic w_unused_hi;
        assign w_unused_hi = ^AluRes[31:ADDR_W+2];
    end

    assign w_accept = ReqValid && (r_state_q == ST_IDLE);

    // Byte enables and lane-replicated write data for the incoming request
    always_comb begin
        w_req_be    = 4'b1111;
        w_req_wdata = StoreData;
        case (MemOp[1:0])
            c_SZ_B: begin
                w_req_be    = 4'b0001 << AluRes[1:0];
                w_req_wdata = {4{StoreData[7:0]}};
            end
            c_SZ_H: begin
                w_req_be    = 4'b0011 << {AluRes[1], 1'b0};
                w_req_wdata = {2{StoreData[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Halfwords need a[0]=0, words need a[1:0]=0; bytes are always aligned
    always_comb begin
        w_misalign = 1'b0;
        if (MemOp[1:0] == c_SZ_H)
            w_misalign = AluRes[0];
        else if (MemOp[1:0] != c_SZ_B)
            w_misalign = (AluRes[1:0] != 2'b00);
    end
`endif

    // Lane select and sign/zero extension of the returned RAM word
    always_comb begin
        w_byte = MemRData[8*r_off_q +: 8];
        w_half = r_off_q[1] ? MemRData[31:16] : MemRData[15:0];
        case (r_op_q[1:0])
            c_SZ_B:  w_fmt = {{24{~r_op_q[2] & w_byte[7]}}, w_byte};
            c_SZ_H:  w_fmt = {{16{~r_op_q[2] & w_half[15]}}, w_half};
            default: w_fmt = MemRData;
        endcase
    end

    // Next-state and request/response datapath
    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_be_d    = r_be_q;
        w_wdata_d = r_wdata_q;
        w_we_d    = r_we_q;
        w_off_d   = r_off_q;
        w_op_d    = r_op_q;
        w_load_d  = r_load_q;
`ifdef MISALIGN_TRAP_EN
        w_err_d   = r_err_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_addr_d  = AluRes[ADDR_W+1:2];
                    w_be_d    = w_req_be;
                    w_wdata_d = w_req_wdata;
                    w_we_d    = MemWrite;      // store wins over load
                    w_off_d   = AluRes[1:0];
                    w_op_d    = MemOp;
`ifdef MISALIGN_TRAP_EN
                    w_err_d   = 1'b0;
`endif
                    if (!(MemRead || MemWrite)) begin
                        w_state_d = ST_RESP;
                        w_load_d  = 32'd0;
`ifdef MISALIGN_TRAP_EN
                    end else if (w_misalign) begin
                        w_state_d = ST_RESP;
                        w_load_d  = 32'd0;
                        w_err_d   = 1'b1;
`endif
                    end else begin
                        w_state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (MemAck) begin
                    w_state_d = ST_RESP;
                    if (!r_we_q)
                        w_load_d = w_fmt;
                end
            end
            ST_RESP:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // State and latched request registers; reset abandons any access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_addr_q  <= '0;
            r_be_q    <= 4'd0;
            r_wdata_q <= 32'd0;
            r_we_q    <= 1'b0;
            r_off_q   <= 2'd0;
            r_op_q    <= 3'd0;
            r_load_q  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            r_err_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_be_q    <= w_be_d;
            r_wdata_q <= w_wdata_d;
            r_we_q    <= w_we_d;
            r_off_q   <= w_off_d;
            r_op_q    <= w_op_d;
            r_load_q  <= w_load_d;
`ifdef MISALIGN_TRAP_EN
            r_err_q   <= w_err_d;
`endif
        end
    end

    assign ReqReady  = (r_state_q == ST_IDLE);
    assign MemReq    = (r_state_q == ST_ACCESS);
    assign MemWe     = r_we_q && MemReq;
    assign MemAddr   = r_addr_q;
    assign MemBe     = r_be_q;
    assign MemWData  = r_wdata_q;
    assign RespValid = (r_state_q == ST_RESP);
    assign LoadData  = r_load_q;
`ifdef MISALIGN_TRAP_EN
    assign RespErr   = r_err_q;
`else
    assign RespErr   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit: table of requests with
//             expected RAM-side values, scoreboard of expected responses, plus
//             hand-written reset-during-access sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ReqValid = 1'b0;
    logic              ReqReady;
    logic [31:0]       AluRes = 32'd0;
    logic [31:0]       StoreData = 32'd0;
    logic [2:0]        MemOp = 3'd0;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [3:0]        MemBe;
    logic [31:0]       MemWData;
    logic [31:0]       MemRData = 32'd0;
    logic              MemAck = 1'b0;
    logic              RespValid;
    logic [31:0]       LoadData;
    logic              RespErr;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .AluRes(AluRes), .StoreData(StoreData), .MemOp(MemOp),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
        .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
        .RespValid(RespValid), .LoadData(LoadData), .RespErr(RespErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic        poke;     // re-assert ReqValid while busy
        logic        mem;      // RAM access expected
        logic [11:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_load;   // loads / non-memory only
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] load;
        logic        err;
    } exp_t;

    localparam int NVEC = 12;
    vec_t  vecs [NVEC];
    exp_t  sb [$];
    logic [31:0] last_ld = 32'd0;
    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_req(input vec_t v);
        exp_t e, got;
        @(negedge clk);
        chk("ready_idle", {31'd0, ReqReady}, 32'd1);
        ReqValid  = 1'b1;
        AluRes    = v.addr;
        StoreData = v.sdata;
        MemOp     = v.op;
        MemRead   = v.rd;
        MemWrite  = v.wr;
        e.load    = v.wr ? last_ld : v.e_load;
        e.err     = v.e_err;
        last_ld   = e.load;
        sb.push_back(e);
        @(negedge clk);
        ReqValid = 1'b0;
        if (v.mem) begin
            chk("be",    {28'd0, MemBe},  {28'd0, v.e_be});
            chk("wdata", MemWData,        v.e_wdata);
            chk("we",    {31'd0, MemWe},  {31'd0, v.wr});
            for (int w = 0; w <= v.waits; w++) begin
                chk("memreq_access", {31'd0, MemReq},   32'd1);
                chk("ready_busy",    {31'd0, ReqReady}, 32'd0);
                chk("addr",          {20'd0, MemAddr},  {20'd0, v.e_addr});
                MemAck   = (w == v.waits);
                MemRData = (w == v.waits) ? v.rdata : 32'hBAD0BAD0;
                if (v.poke) begin
                    ReqValid = 1'b1; AluRes = 32'hFFC; MemWrite = 1'b1;
                    MemOp = 3'b010;
                end
                @(negedge clk);
                MemAck   = 1'b0;
                ReqValid = 1'b0;
            end
        end
        chk("resp_valid", {31'd0, RespValid}, 32'd1);
        chk("memreq_resp", {31'd0, MemReq}, 32'd0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk("load_data", LoadData, got.load);
            chk("resp_err", {31'd0, RespErr}, {31'd0, got.err});
        end
        @(negedge clk);
        chk("resp_pulse_end", {31'd0, RespValid}, 32'd0);
        chk("load_hold", LoadData, last_ld);
    endtask

    initial begin
        //          wr    rd    op      addr          sdata         rdata         w  pk   mem  e_addr  e_be     e_wdata       e_load        err
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1'b0, 1'b1, 12'h4,  4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h13, 32'h000000A5, 32'h0,        0, 1'b0, 1'b1, 12'h4,  4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h13, 32'h0,        32'hA5000000, 0, 1'b0, 1'b1, 12'h4,  4'b1000, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b100, 32'h13, 32'h0,        32'hA5000000, 0, 1'b0, 1'b1, 12'h4,  4'b1000, 32'h0,        32'h000000A5, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h22, 32'h0,        32'h80017FFF, 3, 1'b1, 1'b1, 12'h8,  4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b101, 32'h20, 32'h0,        32'h80017FFF, 1, 1'b0, 1'b1, 12'h8,  4'b0011, 32'h0,        32'h00007FFF, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h0E, 32'h1234ABCD, 32'h0,        0, 1'b0, 1'b1, 12'h3,  4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3'b010, 32'h40, 32'h0,        32'h0,        0, 1'b0, 1'b0, 12'h0,  4'b0000, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h41, 32'h0,        32'h00008000, 2, 1'b0, 1'b1, 12'h10, 4'b0010, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b011, 32'h80, 32'h0,        32'h12345678, 0, 1'b0, 1'b1, 12'h20, 4'b1111, 32'h0,        32'h12345678, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h84, 32'hCAFEF00D, 32'h0,        0, 1'b0, 1'b1, 12'h21, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0};
`ifdef MISALIGN_TRAP_EN
        vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h06, 32'h0,        32'h89ABCDEF, 0, 1'b0, 1'b0, 12'h1,  4'b1111, 32'h0,        32'h0,        1'b1};
`else
        vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h06, 32'h0,        32'h89ABCDEF, 0, 1'b0, 1'b1, 12'h1,  4'b1111, 32'h0,        32'h89ABCDEF, 1'b0};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_memreq",    {31'd0, MemReq},    32'd0);
        chk("rst_respvalid", {31'd0, RespValid}, 32'd0);
        chk("rst_be",        {28'd0, MemBe},     32'd0);
        chk("rst_addr",      {20'd0, MemAddr},   32'd0);
        chk("rst_wdata",     MemWData,           32'd0);
        chk("rst_load",      LoadData,           32'd0);
        chk("rst_err",       {31'd0, RespErr},   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",     {31'd0, ReqReady},  32'd1);

        for (int i = 0; i < NVEC; i++) do_req(vecs[i]);

        // Reset in the second ACCESS cycle, then a late MemAck
        @(negedge clk);
        ReqValid = 1'b1; AluRes = 32'h40; MemOp = 3'b010;
        MemRead = 1'b1; MemWrite = 1'b0; StoreData = 32'd0;
        @(negedge clk);
        ReqValid = 1'b0;
        chk("abort_memreq1", {31'd0, MemReq}, 32'd1);
        @(negedge clk);
        chk("abort_memreq2", {31'd0, MemReq}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_memreq_drop", {31'd0, MemReq},  32'd0);
        chk("abort_be_clear",    {28'd0, MemBe},   32'd0);
        chk("abort_addr_clear",  {20'd0, MemAddr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_ld = 32'd0;
        MemAck = 1'b1; MemRData = 32'h55555555;
        @(negedge clk);
        MemAck = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_ack_respvalid", {31'd0, RespValid}, 32'd0);
            chk("late_ack_memreq",    {31'd0, MemReq},    32'd0);
            chk("late_ack_ready",     {31'd0, ReqReady},  32'd1);
            chk("late_ack_load",      LoadData,           32'd0);
            @(negedge clk);
        end

        // Normal traffic after the abort
        do_req(vecs[2]);
        do_req(vecs[0]);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RISC-V core.
- Takes the ALU result as the effective address, plus the store data and the funct3 access size.
- Runs a handshaked access to the data RAM, which may insert wait states.
- Returns sign- or zero-extended load data to writeback and stalls the pipeline through ReqReady until the access completes.

Parameters:
- ADDR_W, 12, word-address width of the data RAM (MemAddr = AluRes[ADDR_W+1:2]).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ReqValid  input  1  execute stage presents a request.
- ReqReady  output  1  unit can accept a request (high only in IDLE).
- AluRes  input  32  effective byte address from the ALU.
- StoreData  input  32  rs2 value to store.
- MemOp  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MemRead  input  1  load request.
- MemWrite  input  1  store request; takes priority if both MemRead and MemWrite are set.
- MemReq  output  1  RAM access strobe.
- MemWe  output  1  write enable.
- MemAddr  output  ADDR_W  word address.
- MemBe  output  4  byte enables.
- MemWData  output  32  lane-replicated write data.
- MemRData  input  32  RAM read word, valid while MemAck is high.
- MemAck  input  1  RAM completes the access.
- RespValid  output  1  one-cycle completion pulse.
- LoadData  output  32  formatted load result, valid with RespValid.
- RespErr  output  1  misaligned access flag, valid with RespValid.

Behaviour:
- Reset: asynchronous; forces state IDLE.
  - MemReq, MemWe, MemBe, MemAddr, MemWData, RespValid, LoadData and RespErr all go to 0 immediately.
  - ReqReady = 1 once in IDLE.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
  - A request with neither MemRead nor MemWrite set goes IDLE -> RESP, with LoadData = 0 and no RAM cycle.
- IDLE:
  - ReqReady = 1.
  - On ReqValid & ReqReady, latch address, MemOp, StoreData and the read/write type.
  - Next state is ACCESS, or RESP for the non-memory case.
  - MemAck is ignored in IDLE.
- ACCESS:
  - MemReq = 1, with MemWe, MemAddr, MemBe and MemWData held stable from the latched values.
  - Stays in ACCESS for any number of cycles until MemAck = 1.
  - On MemAck, a load latches the formatted MemRData into LoadData; next state RESP.
  - MemReq deasserts in the cycle after MemAck.
- RESP:
  - RespValid = 1 for exactly one cycle; LoadData and RespErr are stable in that cycle.
  - Next state IDLE. LoadData holds its value until the next response.
- Latency: request accepted at cycle 0 -> MemReq at cycle 1 -> RespValid at cycle (1 + wait cycles + 1).
  - Zero-wait RAM (MemAck in the first ACCESS cycle) gives RespValid at cycle 2.
  - Maximum throughput is one request per 3 cycles.
- Byte enables:
  - B: 4'b0001 << a[1:0].
  - H: 4'b0011 << {a[1],1'b0}.
  - W: 4'b1111.
- Write data:
  - B: {4{StoreData[7:0]}}.
  - H: {2{StoreData[15:0]}}.
  - W: StoreData.
- Load formatting:
  - Byte lane is selected by a[1:0]; halfword lane by a[1].
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
- Unused funct3 codes (011, 110, 111) are treated as W.
- Stores never update LoadData; RespValid still pulses.
- Reset during ACCESS:
  - MemReq drops asynchronously and the request is abandoned with no response.
  - A late MemAck after reset is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - At acceptance, H/HU with a[0] = 1, or W with a[1:0] != 0, counts as misaligned.
  - A misaligned request skips ACCESS (no MemReq, RAM untouched) and goes IDLE -> RESP with RespErr = 1 and LoadData = 0.
- Not defined:
  - No checking is done. H/HU ignore a[0]; W ignores a[1:0], so the access is effectively aligned down.
  - RespErr is tied to 0.

Test Plan:
- Reset, then SW at AluRes = 0x0000_0010 with StoreData = 0xDEADBEEF and zero-wait RAM -> MemAddr = 4, MemBe = 1111, MemWData = 0xDEADBEEF, RespValid at cycle 2.
- SB at 0x13 with StoreData = 0x0000_00A5 -> MemBe = 1000, MemWData = 0xA5A5A5A5; then LB at 0x13 with MemRData = 0xA5000000 -> LoadData = 0xFFFFFFA5; LBU at the same address -> 0x000000A5.
- LH at 0x22 with MemRData = 0x80017FFF and 3 wait cycles -> MemReq held high for 4 cycles, ReqReady low throughout, LoadData = 0xFFFF8001 with a one-cycle RespValid.
- ReqValid asserted again during ACCESS -> ignored until IDLE. MemRead = MemWrite = 0 -> RespValid after 1 cycle with no MemReq.
- Assert rst in the second ACCESS cycle, then pulse MemAck -> MemReq drops immediately, no RespValid, and the next request is handled normally.
- With MISALIGN_TRAP_EN defined: LW at 0x06 -> no MemReq, RespErr = 1, LoadData = 0 at cycle 1.
  - Without it: the same request reads word address 1 (byte address 0x04), and RespErr = 0.
